stack_unit: RTL and testbench

- Hardware operand stack: the responder to the control unit's Push / Pop / tos command interface in the multicycle stack CPU.
- Stores words written by the datapath on Push. Returns the top-of-stack word on Pop (destructive) or tos (non-destructive peek).
- Reports full/empty status and sticky overflow/underflow error flags.
- Instantiated inside the datapath. Commands are single-cycle pulses from the controller.

---
 rtl/stack_pkg.sv | 29 ++
 rtl/stack_ram.sv | 25 ++
 rtl/stack_unit.sv | 140 ++++++++++++++
 tb/tb_stack_unit.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Shared constants and command decode for the operand stack used by the
// multicycle stack CPU datapath.
package stack_pkg;

  localparam int STACK_WIDTH = 8;
  localparam int STACK_DEPTH = 16;

  typedef enum logic [2:0] {
    CMD_NOP,
    CMD_PUSH,
    CMD_POP,
    CMD_PEEK,
    CMD_REPLACE,
    CMD_PUSH_PEEK
  } cmd_e;

  // Pop dominates tos; Push combined with a read becomes a single compound command.
  function automatic cmd_e decodeCmd(input logic push, input logic pop, input logic peek);
    cmd_e cmd;
    if (push && pop)       cmd = CMD_REPLACE;
    else if (push && peek) cmd = CMD_PUSH_PEEK;
    else if (push)         cmd = CMD_PUSH;
    else if (pop)          cmd = CMD_POP;
    else if (peek)         cmd = CMD_PEEK;
    else                   cmd = CMD_NOP;
    return cmd;
  endfunction

endpackage

// File: rtl/stack_ram.sv
// DEPTH x WIDTH register array: synchronous write, asynchronous read.
// Contents are deliberately not reset.
module stack_ram
  import stack_pkg::*;
#(
  parameter int WIDTH = STACK_WIDTH,
  parameter int DEPTH = STACK_DEPTH
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/stack_unit.sv
// Operand stack responding to the controller's Push / Pop / tos pulses.
// Holds the stack pointer, status/error flags and the registered read port.
module stack_unit
  import stack_pkg::*;
#(
  parameter int WIDTH = STACK_WIDTH,
  parameter int DEPTH = STACK_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   Push,
  input  logic                   Pop,
  input  logic                   tos,
  input  logic [WIDTH-1:0]       din,
  input  logic                   clr_err,
  output logic [WIDTH-1:0]       dout,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int PTR_W = $clog2(DEPTH);

  // sp doubles as the entry count: it is one bit wider so DEPTH is representable.
  logic [PTR_W:0]   r_sp;
  logic [WIDTH-1:0] r_dout;
  logic             r_empty;
  logic             r_full;
  logic             r_overflow;
  logic             r_underflow;

  cmd_e             w_cmd;
  logic             w_we;
  logic [PTR_W-1:0] w_waddr;
  logic [PTR_W-1:0] w_freeAddr;
  logic [PTR_W-1:0] w_topAddr;
  logic [WIDTH-1:0] w_rdata;
  logic [PTR_W:0]   w_spNext;
  logic             w_loadDout;
  logic             w_ovfEv;
  logic             w_udfEv;

  assign w_freeAddr = r_sp[PTR_W-1:0];
  assign w_topAddr  = r_sp[PTR_W-1:0] - PTR_W'(1);

  stack_ram #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_ram (
    .clk  (clk),
    .we   (w_we & ~rst),
    .waddr(w_waddr),
    .wdata(din),
    .raddr(w_topAddr),
    .rdata(w_rdata)
  );

  always_comb begin
    w_cmd      = decodeCmd(Push, Pop, tos);
    w_we       = 1'b0;
    w_waddr    = w_freeAddr;
    w_spNext   = r_sp;
    w_loadDout = 1'b0;
    w_ovfEv    = 1'b0;
    w_udfEv    = 1'b0;
    case (w_cmd)
      CMD_PUSH: begin
        if (!r_full) begin
          w_we     = 1'b1;
          w_spNext = r_sp + (PTR_W+1)'(1);
        end else begin
          w_ovfEv = 1'b1;
        end
      end
      CMD_POP: begin
        if (!r_empty) begin
          w_loadDout = 1'b1;
          w_spNext   = r_sp - (PTR_W+1)'(1);
        end else begin
          w_udfEv = 1'b1;
        end
      end
      CMD_PEEK: begin
        if (!r_empty) w_loadDout = 1'b1;
        else          w_udfEv    = 1'b1;
      end
      CMD_REPLACE: begin
        // On an empty stack the push half still lands in slot 0.
        w_we = 1'b1;
        if (!r_empty) begin
          w_loadDout = 1'b1;
          w_waddr    = w_topAddr;
        end else begin
          w_udfEv  = 1'b1;
          w_spNext = r_sp + (PTR_W+1)'(1);
        end
      end
      CMD_PUSH_PEEK: begin
        if (!r_empty) w_loadDout = 1'b1;
        else          w_udfEv    = 1'b1;
        if (!r_full) begin
          w_we     = 1'b1;
          w_spNext = r_sp + (PTR_W+1)'(1);
        end else begin
          w_ovfEv = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Error flags: a new event in the same cycle as clr_err keeps its flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sp        <= '0;
      r_dout      <= '0;
      r_empty     <= 1'b1;
      r_full      <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_sp        <= w_spNext;
      r_empty     <= (w_spNext == '0);
      r_full      <= (w_spNext == (PTR_W+1)'(DEPTH));
      r_overflow  <= (r_overflow & ~clr_err) | w_ovfEv;
      r_underflow <= (r_underflow & ~clr_err) | w_udfEv;
      if (w_loadDout) r_dout <= w_rdata;
    end
  end

  assign dout      = r_dout;
  assign empty     = r_empty;
  assign full      = r_full;
  assign count     = r_sp;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule

// File: tb/tb_stack_unit.sv
// Scoreboard bench for stack_unit: a queue-based stack model predicts every
// cycle's outputs; a monitor compares them one clock edge later.
module tb_stack_unit;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             Push = 1'b0;
  logic             Pop = 1'b0;
  logic             tos = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic             clr_err = 1'b0;
  logic [WIDTH-1:0] dout;
  logic             empty;
  logic             full;
  logic [4:0]       count;
  logic             overflow;
  logic             underflow;

  stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .Push     (Push),
    .Pop      (Pop),
    .tos      (tos),
    .din      (din),
    .clr_err  (clr_err),
    .dout     (dout),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .overflow (overflow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    string            name;
    logic [WIDTH-1:0] dout;
    int               count;
    bit               empty;
    bit               full;
    bit               ovf;
    bit               udf;
  } exp_t;

  exp_t sbQ[$];

  int assertCount = 0;
  int failCount   = 0;

  // Reference model state
  int               mStack[$];
  logic [WIDTH-1:0] mDout = '0;
  bit               mOvf  = 1'b0;
  bit               mUdf  = 1'b0;

  task automatic checkOutput(input string name, input string field,
                             input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s.%s actual=0x%0h required=0x%0h", name, field, actual, expected);
    end
  endtask

  // Predict this cycle's effect from the command bits, then drive them.
  task automatic applyStimulus(input bit push, input bit pop, input bit peek,
                               input logic [WIDTH-1:0] data, input bit clr,
                               input bit doRst, input string name);
    exp_t e;
    bit ovfEv, udfEv;
    @(negedge clk);
    Push = push; Pop = pop; tos = peek; din = data; clr_err = clr; rst = doRst;
    ovfEv = 1'b0;
    udfEv = 1'b0;
    if (doRst) begin
      mStack.delete();
      mDout = '0;
      mOvf  = 1'b0;
      mUdf  = 1'b0;
    end else begin
      if (pop) begin
        if (mStack.size() == 0) begin
          udfEv = 1'b1;
          if (push) mStack.push_back(int'(data));
        end else begin
          mDout = WIDTH'(mStack[$]);
          if (push) mStack[mStack.size()-1] = int'(data);
          else void'(mStack.pop_back());
        end
      end else begin
        if (peek) begin
          if (mStack.size() == 0) udfEv = 1'b1;
          else mDout = WIDTH'(mStack[$]);
        end
        if (push) begin
          if (mStack.size() < DEPTH) mStack.push_back(int'(data));
          else ovfEv = 1'b1;
        end
      end
      mOvf = (mOvf && !clr) || ovfEv;
      mUdf = (mUdf && !clr) || udfEv;
    end
    e.name  = name;
    e.dout  = mDout;
    e.count = mStack.size();
    e.empty = (mStack.size() == 0);
    e.full  = (mStack.size() == DEPTH);
    e.ovf   = mOvf;
    e.udf   = mUdf;
    sbQ.push_back(e);
  endtask

  // Monitor: outputs settle after the edge that sampled the queued stimulus.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbQ.size() > 0) begin
        e = sbQ.pop_front();
        checkOutput(e.name, "dout",      32'(dout),      32'(e.dout));
        checkOutput(e.name, "count",     32'(count),     32'(e.count));
        checkOutput(e.name, "empty",     32'(empty),     32'(e.empty));
        checkOutput(e.name, "full",      32'(full),      32'(e.full));
        checkOutput(e.name, "overflow",  32'(overflow),  32'(e.ovf));
        checkOutput(e.name, "underflow", 32'(underflow), 32'(e.udf));
      end
    end
  end

  task automatic idle(input string name);
    applyStimulus(0, 0, 0, '0, 0, 0, name);
  endtask

  initial begin
    int pushPct;
    int popPct;
    int waitCycles;
    logic [WIDTH-1:0] v;

    applyStimulus(0, 0, 0, '0, 0, 1, "reset");

    // Basic push / peek / pop ordering
    applyStimulus(1, 0, 0, 8'h11, 0, 0, "push11");
    applyStimulus(1, 0, 0, 8'h22, 0, 0, "push22");
    applyStimulus(1, 0, 0, 8'h33, 0, 0, "push33");
    applyStimulus(0, 0, 1, '0, 0, 0, "tos33");
    applyStimulus(0, 1, 0, '0, 0, 0, "pop33");
    applyStimulus(0, 1, 0, '0, 0, 0, "pop22");
    applyStimulus(0, 1, 0, '0, 0, 0, "pop11");
    applyStimulus(0, 1, 0, '0, 0, 0, "popEmpty");
    applyStimulus(0, 0, 0, '0, 1, 0, "clrUdf");

    // Fill to DEPTH, overflow, and confirm the rejected word was not stored
    for (int i = 0; i < DEPTH; i++) begin
      v = WIDTH'(i);
      applyStimulus(1, 0, 0, v, 0, 0, "fill");
    end
    applyStimulus(1, 0, 0, 8'hAA, 0, 0, "pushFull");
    applyStimulus(0, 1, 0, '0, 0, 0, "popAfterOvf");
    applyStimulus(1, 0, 0, 8'hBB, 0, 0, "refill");
    applyStimulus(1, 1, 0, 8'hCC, 0, 0, "replaceFull");
    applyStimulus(1, 0, 1, 8'hDD, 0, 0, "pushPeekFull");
    applyStimulus(0, 0, 1, '0, 1, 0, "tosClr");

    // Replace-top and peek of the new top
    applyStimulus(0, 0, 0, '0, 0, 1, "reset2");
    applyStimulus(1, 0, 0, 8'h05, 0, 0, "push05");
    applyStimulus(1, 0, 0, 8'h07, 0, 0, "push07");
    applyStimulus(1, 1, 0, 8'h09, 0, 0, "replace09");
    applyStimulus(0, 0, 1, '0, 0, 0, "tos09");
    applyStimulus(1, 0, 1, 8'h0A, 0, 0, "pushPeek");
    applyStimulus(0, 1, 1, '0, 0, 0, "popAndTos");

    // Sticky underflow versus clr_err, and compound commands on empty
    applyStimulus(0, 0, 0, '0, 0, 1, "reset3");
    applyStimulus(0, 1, 0, '0, 0, 0, "udfSet");
    applyStimulus(0, 1, 0, '0, 1, 0, "clrWithPop");
    applyStimulus(0, 0, 0, '0, 1, 0, "clrAlone");
    applyStimulus(1, 1, 0, 8'h5A, 0, 0, "replaceEmpty");
    applyStimulus(0, 1, 0, '0, 1, 0, "pop5A");
    applyStimulus(1, 0, 1, 8'h6B, 0, 0, "pushPeekEmpty");

    // Reset beats a concurrent Pop
    applyStimulus(1, 0, 0, 8'h44, 1, 0, "push44a");
    applyStimulus(1, 0, 0, 8'h44, 0, 0, "push44b");
    applyStimulus(0, 1, 0, '0, 0, 1, "rstWithPop");
    applyStimulus(0, 1, 0, '0, 0, 0, "popAfterRst");
    idle("idle");

    // Random phases with different push bias to visit both boundaries
    for (int phase = 0; phase < 4; phase++) begin
      case (phase)
        0:       begin pushPct = 80; popPct = 20; end
        1:       begin pushPct = 25; popPct = 70; end
        2:       begin pushPct = 60; popPct = 40; end
        default: begin pushPct = 50; popPct = 50; end
      endcase
      for (int i = 0; i < 500; i++) begin
        applyStimulus($urandom_range(0, 99) < pushPct,
                      $urandom_range(0, 99) < popPct,
                      $urandom_range(0, 99) < 25,
                      WIDTH'($urandom),
                      $urandom_range(0, 99) < 6,
                      $urandom_range(0, 199) == 0,
                      "random");
      end
    end

    applyStimulus(0, 0, 0, '0, 0, 0, "drain");
    Push = 0; Pop = 0; tos = 0; clr_err = 0; rst = 0;

    waitCycles = 0;
    while (sbQ.size() > 0 && waitCycles < 10) begin
      @(posedge clk);
      #2;
      waitCycles++;
    end
    assertCount++;
    if (sbQ.size() > 0) begin
      failCount++;
      $display("[TB] FAIL scoreboardDrain actual=%0d pending required=0", sbQ.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
